// File: rtl/ps2_key_fifo.sv
// ----------------------------------------------------------------------------
// ps2_key_fifo
//   Decodes the PS/2 set-2 byte stream (E0 extended prefix, F0 break prefix)
//   into single key events and queues them in a small first-word-fall-through
//   FIFO that the processor polls and pops at its own rate.
//
//   Event format: {is_break, is_ext, code[7:0]}
//
//   Optional build macro: PS2_KEY_FIFO_TYPEMATIC_FILTER_EN
//     When defined, typematic repeats of the currently held key are dropped
//     before they reach the FIFO (a held-key register tracks the last make).
//
// Ports:
//   clock           system clock
//   resetn          asynchronous active-low reset
//   ps2_key_pressed one-cycle strobe, ps2_key_data holds a new byte
//   ps2_key_data    received scan byte
//   rd_en           pop head event (ignored when empty)
//   rd_data         head event, 0 when empty
//   empty / full    FIFO status
//   count           number of queued events, 0..DEPTH
//   overflow        sticky drop indicator
//   clr_overflow    clears overflow (a simultaneous drop wins)
// ----------------------------------------------------------------------------
module ps2_key_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ps2_key_pressed,
    input  logic [7:0]        ps2_key_data,
    input  logic              rd_en,
    output logic [9:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              state_r;
    state_t              state_next_s;
    logic                ev_valid_s;
    logic [9:0]          ev_data_s;
    logic                push_ok_s;

    logic                push_valid_r;
    logic [9:0]          push_data_r;

    logic [9:0]          mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_next_s;
    logic [ADDR_W:0]     count_next_s;
    logic                do_pop_s;
    logic                do_push_s;
    logic                drop_s;
    logic                overflow_next_s;
    logic [9:0]          rd_data_next_s;

    // Decoder next-state: folds prefix bytes into one event per key code.
    always_comb begin
        state_next_s = state_r;
        ev_valid_s   = 1'b0;
        ev_data_s    = 10'd0;
        if (ps2_key_pressed) begin
            if ((ps2_key_data == 8'h00) || (ps2_key_data == 8'hFF)) begin
                // Keyboard error codes abandon any partial sequence.
                state_next_s = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (ps2_key_data == 8'hE0) begin
                            state_next_s = ST_E0;
                        end else if (ps2_key_data == 8'hF0) begin
                            state_next_s = ST_F0;
                        end else begin
                            ev_valid_s = 1'b1;
                            ev_data_s  = {2'b00, ps2_key_data};
                        end
                    end
                    ST_E0: begin
                        if (ps2_key_data == 8'hE0) begin
                            state_next_s = ST_E0;
                        end else if (ps2_key_data == 8'hF0) begin
                            state_next_s = ST_E0F0;
                        end else begin
                            ev_valid_s   = 1'b1;
                            ev_data_s    = {2'b01, ps2_key_data};
                            state_next_s = ST_IDLE;
                        end
                    end
                    ST_F0: begin
                        if (ps2_key_data == 8'hF0) begin
                            state_next_s = ST_F0;
                        end else if (ps2_key_data == 8'hE0) begin
                            state_next_s = ST_E0F0;
                        end else begin
                            ev_valid_s   = 1'b1;
                            ev_data_s    = {2'b10, ps2_key_data};
                            state_next_s = ST_IDLE;
                        end
                    end
                    ST_E0F0: begin
                        if ((ps2_key_data == 8'hE0) || (ps2_key_data == 8'hF0)) begin
                            state_next_s = ST_E0F0;
                        end else begin
                            ev_valid_s   = 1'b1;
                            ev_data_s    = {2'b11, ps2_key_data};
                            state_next_s = ST_IDLE;
                        end
                    end
                    default: begin
                        state_next_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // Decoder state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef PS2_KEY_FIFO_TYPEMATIC_FILTER_EN
    logic       held_valid_r;
    logic       held_ext_r;
    logic [7:0] held_code_r;
    logic       held_valid_next_s;
    logic       held_ext_next_s;
    logic [7:0] held_code_next_s;
    logic       held_match_s;

    // Typematic filter: suppress repeated makes of the key currently held.
    always_comb begin
        push_ok_s         = ev_valid_s;
        held_valid_next_s = held_valid_r;
        held_ext_next_s   = held_ext_r;
        held_code_next_s  = held_code_r;
        held_match_s      = held_valid_r && (held_ext_r == ev_data_s[8])
                            && (held_code_r == ev_data_s[7:0]);
        if (ev_valid_s) begin
            if (!ev_data_s[9]) begin
                if (held_match_s) begin
                    push_ok_s = 1'b0;
                end else begin
                    held_valid_next_s = 1'b1;
                    held_ext_next_s   = ev_data_s[8];
                    held_code_next_s  = ev_data_s[7:0];
                end
            end else begin
                // Breaks always go through; a matching break releases the key.
                if (held_match_s) begin
                    held_valid_next_s = 1'b0;
                end else begin
                    held_valid_next_s = held_valid_r;
                end
            end
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Held-key register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            held_valid_r <= 1'b0;
            held_ext_r   <= 1'b0;
            held_code_r  <= 8'd0;
        end else begin
            held_valid_r <= held_valid_next_s;
            held_ext_r   <= held_ext_next_s;
            held_code_r  <= held_code_next_s;
        end
    end
`else
    // Without the filter every decoded event is queued.
    always_comb begin
        push_ok_s = ev_valid_s;
    end
`endif

    // Push stage: the decoded event is written into the FIFO one edge later.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            push_valid_r <= 1'b0;
            push_data_r  <= 10'd0;
        end else begin
            push_valid_r <= push_ok_s;
            push_data_r  <= ev_data_s;
        end
    end

    // FIFO next-state: pointers, occupancy, overflow and next head value.
    always_comb begin
        do_pop_s        = rd_en && !empty;
        // When full, a same-cycle pop frees the slot the push needs.
        do_push_s       = push_valid_r && (!full || do_pop_s);
        drop_s          = push_valid_r && full && !do_pop_s;
        rd_ptr_next_s   = do_pop_s ? (rd_ptr_r + ADDR_W'(1)) : rd_ptr_r;
        count_next_s    = count;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count + (ADDR_W + 1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_next_s = count - (ADDR_W + 1)'(1);
        end else begin
            count_next_s = count;
        end
        if (drop_s) begin
            overflow_next_s = 1'b1;
        end else if (clr_overflow) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow;
        end
        // Registered FWFT head: if the FIFO is (or becomes) otherwise empty,
        // the new head is the entry being written this very edge.
        if (count_next_s == (ADDR_W + 1)'(0)) begin
            rd_data_next_s = 10'd0;
        end else if (do_push_s && (count - (do_pop_s ? (ADDR_W + 1)'(1) : (ADDR_W + 1)'(0)))
                     == (ADDR_W + 1)'(0)) begin
            rd_data_next_s = push_data_r;
        end else begin
            rd_data_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO control registers and registered status outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rd_data  <= 10'd0;
        end else begin
            wr_ptr_r <= do_push_s ? (wr_ptr_r + ADDR_W'(1)) : wr_ptr_r;
            rd_ptr_r <= rd_ptr_next_s;
            count    <= count_next_s;
            empty    <= (count_next_s == (ADDR_W + 1)'(0));
            full     <= (count_next_s == DEPTH_C);
            overflow <= overflow_next_s;
            rd_data  <= rd_data_next_s;
        end
    end

endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;

    logic        clock;
    logic        resetn;
    logic        ps2_key_pressed;
    logic [7:0]  ps2_key_data;
    logic        rd_en;
    logic [9:0]  rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        clr_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    ps2_key_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .empty           (empty),
        .full            (full),
        .count           (count),
        .overflow        (overflow),
        .clr_overflow    (clr_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Strobe one byte for exactly one cycle; consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        tick();
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (rd_data !== 10'h000) begin tests_failed++; $display("FAIL reset_rd_data got %h exp %h", rd_data, 10'h000); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b exp 1", empty); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b exp 0", full); end
        tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_single_make();
        send(8'h1D);
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL latency_empty got %b exp 1", empty); end
        tick();
        tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("FAIL single_empty got %b exp 0", empty); end
        tests_run++; if (count !== 4'd1) begin tests_failed++; $display("FAIL single_count got %0d exp 1", count); end
        tests_run++; if (rd_data !== 10'h01D) begin tests_failed++; $display("FAIL single_data got %h exp %h", rd_data, 10'h01D); end
        pop();
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL single_pop_empty got %b exp 1", empty); end
        tests_run++; if (rd_data !== 10'h000) begin tests_failed++; $display("FAIL single_pop_data got %h exp 000", rd_data); end
    endtask

    task automatic test_ext_break();
        send(8'hE0); send(8'hF0); send(8'h75);
        tick();
        tests_run++; if (count !== 4'd1) begin tests_failed++; $display("FAIL extbrk_count got %0d exp 1", count); end
        tests_run++; if (rd_data !== 10'h375) begin tests_failed++; $display("FAIL extbrk_data got %h exp %h", rd_data, 10'h375); end
        pop();
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL extbrk_empty got %b exp 1", empty); end
    endtask

    task automatic test_order_and_errors();
        send(8'hF0); send(8'h1C); send(8'hE0); send(8'h74);
        tick();
        tests_run++; if (count !== 4'd2) begin tests_failed++; $display("FAIL order_count got %0d exp 2", count); end
        tests_run++; if (rd_data !== 10'h21C) begin tests_failed++; $display("FAIL order_first got %h exp %h", rd_data, 10'h21C); end
        pop();
        tests_run++; if (rd_data !== 10'h174) begin tests_failed++; $display("FAIL order_second got %h exp %h", rd_data, 10'h174); end
        pop();
        // 0x00 after F0 abandons the break prefix; nothing is queued for it.
        send(8'hF0); send(8'h00); send(8'hE0); send(8'h74);
        tick();
        tests_run++; if (count !== 4'd1) begin tests_failed++; $display("FAIL err00_count got %0d exp 1", count); end
        tests_run++; if (rd_data !== 10'h174) begin tests_failed++; $display("FAIL err00_data got %h exp %h", rd_data, 10'h174); end
        pop();
        // 0xFF after E0 drops the extended prefix, 74 becomes a plain make.
        send(8'hE0); send(8'hFF); send(8'h74);
        tick();
        tests_run++; if (count !== 4'd1) begin tests_failed++; $display("FAIL errff_count got %0d exp 1", count); end
        tests_run++; if (rd_data !== 10'h074) begin tests_failed++; $display("FAIL errff_data got %h exp %h", rd_data, 10'h074); end
        pop();
        // rd_en on an empty FIFO is ignored.
        pop();
        tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL empty_pop_count got %0d exp 0", count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        tick();
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full got %b exp 1", full); end
        tests_run++; if (count !== 4'd8) begin tests_failed++; $display("FAIL ovf_count got %0d exp 8", count); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            tests_run++; if (rd_data !== (10'h010 + 10'(i))) begin tests_failed++; $display("FAIL ovf_pop%0d got %h exp %h", i, rd_data, 10'h010 + 10'(i)); end
            pop();
        end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL ovf_drained got %b exp 1", empty); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
        tick();
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL b2b_full got %b exp 1", full); end
        // 0x20 is written on the edge after its strobe; pop on that same edge.
        send(8'h20);
        pop();
        tests_run++; if (count !== 4'd8) begin tests_failed++; $display("FAIL b2b_count got %0d exp 8", count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
        for (int i = 1; i < 8; i++) begin
            tests_run++; if (rd_data !== (10'h030 + 10'(i))) begin tests_failed++; $display("FAIL b2b_pop%0d got %h exp %h", i, rd_data, 10'h030 + 10'(i)); end
            pop();
        end
        tests_run++; if (rd_data !== 10'h020) begin tests_failed++; $display("FAIL b2b_last got %h exp %h", rd_data, 10'h020); end
        pop();
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty got %b exp 1", empty); end
        // Push plus pop on an empty FIFO: the pop is ignored.
        send(8'h21);
        pop();
        tests_run++; if (count !== 4'd1) begin tests_failed++; $display("FAIL empty_pp_count got %0d exp 1", count); end
        tests_run++; if (rd_data !== 10'h021) begin tests_failed++; $display("FAIL empty_pp_data got %h exp %h", rd_data, 10'h021); end
        pop();
    endtask

    task automatic test_reset_mid_sequence();
        send(8'h44);
        send(8'hE0);
        do_reset();
        tests_run++; if (count !== 4'd0) begin tests_failed++; $display("FAIL rstmid_count got %0d exp 0", count); end
        send(8'h74);
        tick();
        tests_run++; if (rd_data !== 10'h074) begin tests_failed++; $display("FAIL rstmid_data got %h exp %h", rd_data, 10'h074); end
        pop();
    endtask

    task automatic test_typematic();
        logic [9:0] exp_q [$];
        int n;
        send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D); send(8'h1D);
        tick();
`ifdef PS2_KEY_FIFO_TYPEMATIC_FILTER_EN
        exp_q = '{10'h01D, 10'h21D, 10'h01D};
`else
        exp_q = '{10'h01D, 10'h01D, 10'h01D, 10'h21D, 10'h01D};
`endif
        n = exp_q.size();
        tests_run++; if (count !== 4'(n)) begin tests_failed++; $display("FAIL typ_count got %0d exp %0d", count, n); end
        for (int i = 0; i < n; i++) begin
            tests_run++; if (rd_data !== exp_q[i]) begin tests_failed++; $display("FAIL typ_ev%0d got %h exp %h", i, rd_data, exp_q[i]); end
            pop();
        end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL typ_empty got %b exp 1", empty); end
    endtask

    initial begin
        resetn          = 1'b1;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        rd_en           = 1'b0;
        clr_overflow    = 1'b0;
        #2;
        test_reset();
        test_single_make();
        test_ext_break();
        test_order_and_errors();
        test_overflow();
        test_back_to_back();
        test_reset_mid_sequence();
        test_typematic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
